// File: rtl/mips_pkg.sv
// Shared MIPS definitions: divider FSM encoding, divider width and the
// ALUControl codes the decoder emits for div/divu.
package mips_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    localparam logic [3:0] ALU_DIV  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the result if it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The extra top bit keeps the shifted remainder exact; diff[WIDTH] is the borrow.
    assign shifted = {rem_in, q_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        rem_out = shifted[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_out = diff[WIDTH-1:0];
            q_out   = {q_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit_seq.sv
// Iterative restoring divider for div/divu: magnitudes in PREP, WIDTH
// shift/subtract steps in ITER, sign fix-up in FIX, HI/LO strobe in DONE.
module div_unit_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sgn_reg;
    logic             neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0] rem_reg, q_reg, dvs_reg;
    logic [WIDTH-1:0] quot_reg, remd_reg;
    logic             dbz_reg;

    logic             accept;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_rem, step_q;

    assign accept = start && !flush && (state_reg == IDLE || state_reg == DONE);
    assign b_zero = (b_reg == '0);
    assign mag_a  = (sgn_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign mag_b  = (sgn_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .q_in    (q_reg),
        .divisor (dvs_reg),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start) state_next = PREP;
                PREP:    state_next = b_zero ? DONE : ITER;
                ITER:    if (cnt_reg == CNT_LAST) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    state_next = start ? PREP : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            rem_reg   <= '0;
            q_reg     <= '0;
            dvs_reg   <= '0;
            quot_reg  <= '0;
            remd_reg  <= '0;
            dbz_reg   <= 1'b0;
        end else if (accept) begin
            a_reg   <= A;
            b_reg   <= B;
            sgn_reg <= is_signed;
        end else if (!flush) begin
            case (state_reg)
                PREP: begin
                    neg_q_reg <= sgn_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    neg_r_reg <= sgn_reg && a_reg[WIDTH-1];
                    rem_reg   <= '0;
                    q_reg     <= mag_a;
                    dvs_reg   <= mag_b;
                    cnt_reg   <= '0;
                    // Divide by zero completes here with the architectural fallback values.
                    if (b_zero) begin
                        quot_reg <= '1;
                        remd_reg <= a_reg;
                        dbz_reg  <= 1'b1;
                    end
                end
                ITER: begin
                    rem_reg <= step_rem;
                    q_reg   <= step_q;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                FIX: begin
                    quot_reg <= neg_q_reg ? -q_reg : q_reg;
                    remd_reg <= neg_r_reg ? -rem_reg : rem_reg;
                    dbz_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg == PREP) || (state_reg == ITER) || (state_reg == FIX);
    assign done        = (state_reg == DONE);
    assign stall       = busy || accept;
    assign quotient    = quot_reg;
    assign remainder   = remd_reg;
    assign div_by_zero = dbz_reg;

endmodule
